// File: rtl/imem_pipelined_if.sv
// Fetch/load bus for imem_pipelined.
//   req_*  : fetch request (valid/ready, byte address)
//   rsp_*  : fetch response (valid/ready, data word, 2-bit status)
//   wr_*   : load port (strobe, byte address, data) and one-cycle reject pulse
// The slave modport is the memory side; master is the fetch/load side.
interface imem_pipelined_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0]        rsp_err;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_err;

  modport slave (
    input  req_valid, req_addr, rsp_ready, wr_en, wr_addr, wr_data,
    output req_ready, rsp_valid, rsp_data, rsp_err, wr_err
  );

  modport master (
    output req_valid, req_addr, rsp_ready, wr_en, wr_addr, wr_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err, wr_err
  );
endinterface

// File: rtl/imem_pipelined.sv
// Pipelined instruction memory with a side load port.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset (clears pipeline and wr_err, not storage)
//   bus  : imem_pipelined_if.slave -- fetch request/response and load port
// A fetch accepted in cycle N is returned LATENCY cycles later while the output
// advances; the whole pipeline stalls together when the response is not taken.
// Status codes: 00 ok, 01 misaligned (wins), 10 out of range. Erroring fetches
// return zero data and never touch storage. Rejected writes pulse wr_err.
// Storage is not reset; its power-up contents come from device configuration
// (all zeros).
module imem_pipelined #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 1
) (
  input logic           clk,
  input logic           rst,
  imem_pipelined_if.slave bus
);

  localparam int unsigned OFFS_W = $clog2(DATA_W / 8);
  localparam int unsigned IDX_W  = ADDR_W - OFFS_W;
  localparam int unsigned MEM_AW = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_wr_err;

  logic              w_adv;
  logic              w_acc;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [1:0]        w_rd_err;
  logic              w_wr_bad;
  logic              w_rsp_valid;

  assign w_adv    = !w_rsp_valid || bus.rsp_ready;
  assign w_acc    = bus.req_valid && w_adv;
  assign w_rd_idx = bus.req_addr[ADDR_W-1:OFFS_W];
  assign w_wr_idx = bus.wr_addr[ADDR_W-1:OFFS_W];

  // Misaligned is checked first so it wins over out of range.
  always_comb begin
    w_rd_err = 2'b00;
    if (bus.req_addr[OFFS_W-1:0] != '0) begin
      w_rd_err = 2'b01;
    end else if (w_rd_idx >= DEPTH_IDX) begin
      w_rd_err = 2'b10;
    end
  end

  assign w_wr_bad = (bus.wr_addr[OFFS_W-1:0] != '0) || (w_wr_idx >= DEPTH_IDX);

  // Load port is independent of the read pipeline's stall state.
  always_ff @(posedge clk) begin
    if (!rst && bus.wr_en && !w_wr_bad) begin
      r_mem[w_wr_idx[MEM_AW-1:0]] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= bus.wr_en && w_wr_bad;
    end
  end

  // Read pipeline: stage 0 samples storage at acceptance, so a same-cycle
  // write to that word is seen only by later fetches (read-first).
  for (genvar g = 0; g < LATENCY; g++) begin : g_stage
    logic              r_vld;
    logic [1:0]        r_err;
    logic [DATA_W-1:0] r_dat;
    logic              w_in_vld;
    logic [1:0]        w_in_err;
    logic [DATA_W-1:0] w_in_dat;

    if (g == 0) begin : g_head
      assign w_in_vld = w_acc;
      assign w_in_err = w_acc ? w_rd_err : 2'b00;
      assign w_in_dat = (w_acc && (w_rd_err == 2'b00)) ? r_mem[w_rd_idx[MEM_AW-1:0]] : '0;
    end else begin : g_tail
      assign w_in_vld = g_stage[g-1].r_vld;
      assign w_in_err = g_stage[g-1].r_err;
      assign w_in_dat = g_stage[g-1].r_dat;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld <= 1'b0;
        r_err <= 2'b00;
      end else if (w_adv) begin
        r_vld <= w_in_vld;
        r_err <= w_in_err;
      end
    end

    always_ff @(posedge clk) begin
      if (w_adv) begin
        r_dat <= w_in_dat;
      end
    end
  end

  assign w_rsp_valid   = g_stage[LATENCY-1].r_vld;
  assign bus.req_ready = w_adv;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_data  = g_stage[LATENCY-1].r_dat;
  assign bus.rsp_err   = g_stage[LATENCY-1].r_err;
  assign bus.wr_err    = r_wr_err;

endmodule

// File: tb/tb_imem_pipelined.sv
// Directed bench for imem_pipelined: a LATENCY=2 instance driven by a vector
// table plus hand sequences (backpressure, reset mid-flight), and a LATENCY=4
// instance for the latency rerun of load/fetch.
module tb_imem_pipelined;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   n_checks;
  int   n_pass;

  imem_pipelined_if #(.DATA_W(32), .ADDR_W(32)) bus_a ();
  imem_pipelined_if #(.DATA_W(32), .ADDR_W(32)) bus_b ();

  imem_pipelined #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .LATENCY(2)) u_dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  imem_pipelined #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .LATENCY(4)) u_dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        rsp_ready;
    logic        e_rv;
    logic [31:0] e_data;
    logic [1:0]  e_err;
    logic        e_rr;
    logic        e_we;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                              input logic rv, input logic [31:0] ra, input logic rr,
                              input logic e_rv, input logic [31:0] e_data,
                              input logic [1:0] e_err, input logic e_rr, input logic e_we);
    vec_t v;
    v.wr_en = we;   v.wr_addr = wa;   v.wr_data = wd;
    v.req_valid = rv; v.req_addr = ra; v.rsp_ready = rr;
    v.e_rv = e_rv;  v.e_data = e_data; v.e_err = e_err;
    v.e_rr = e_rr;  v.e_we = e_we;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 time unit later.
  task automatic step_a(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                        input logic rv, input logic [31:0] ra, input logic rr,
                        input logic rs);
    @(negedge clk);
    rst_a = rs;
    bus_a.wr_en = we;     bus_a.wr_addr = wa;   bus_a.wr_data = wd;
    bus_a.req_valid = rv; bus_a.req_addr = ra;  bus_a.rsp_ready = rr;
    #1;
  endtask

  task automatic step_b(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                        input logic rv, input logic [31:0] ra);
    @(negedge clk);
    bus_b.wr_en = we;     bus_b.wr_addr = wa;   bus_b.wr_data = wd;
    bus_b.req_valid = rv; bus_b.req_addr = ra;  bus_b.rsp_ready = 1'b1;
    #1;
  endtask

  task automatic chk_a(input string name, input logic e_rv, input logic [31:0] e_data,
                       input logic [1:0] e_err, input logic e_rr);
    chk({name, " rsp_valid"}, 64'(bus_a.rsp_valid), 64'(e_rv));
    chk({name, " rsp_err"}, 64'(bus_a.rsp_err), 64'(e_err));
    chk({name, " req_ready"}, 64'(bus_a.req_ready), 64'(e_rr));
    if (e_rv) chk({name, " rsp_data"}, 64'(bus_a.rsp_data), 64'(e_data));
  endtask

  task automatic chk_b(input string name, input logic e_rv, input logic [31:0] e_data);
    chk({name, " rsp_valid"}, 64'(bus_b.rsp_valid), 64'(e_rv));
    chk({name, " rsp_err"}, 64'(bus_b.rsp_err), 64'(2'b00));
    if (e_rv) chk({name, " rsp_data"}, 64'(bus_b.rsp_data), 64'(e_data));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
    bus_a.req_valid = 1'b0; bus_a.req_addr = '0; bus_a.rsp_ready = 1'b1;
    bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
    bus_b.req_valid = 1'b0; bus_b.req_addr = '0; bus_b.rsp_ready = 1'b1;

    // Load/fetch, errors, rejected write, read-first (rsp_ready held high).
    tbl[0]  = mk(1, 32'h0,    32'hA00000AA, 0, 32'h0,    1, 0, 32'h0,        2'b00, 1, 0);
    tbl[1]  = mk(1, 32'h4,    32'h10000011, 0, 32'h0,    1, 0, 32'h0,        2'b00, 1, 0);
    tbl[2]  = mk(0, 32'h0,    32'h0,        1, 32'h0,    1, 0, 32'h0,        2'b00, 1, 0);
    tbl[3]  = mk(0, 32'h0,    32'h0,        1, 32'h4,    1, 0, 32'h0,        2'b00, 1, 0);
    tbl[4]  = mk(0, 32'h0,    32'h0,        0, 32'h0,    1, 1, 32'hA00000AA, 2'b00, 1, 0);
    tbl[5]  = mk(0, 32'h0,    32'h0,        0, 32'h0,    1, 1, 32'h10000011, 2'b00, 1, 0);
    tbl[6]  = mk(1, 32'hC,    32'h00000033, 0, 32'h0,    1, 0, 32'h0,        2'b00, 1, 0);
    tbl[7]  = mk(0, 32'h0,    32'h0,        1, 32'h2,    1, 0, 32'h0,        2'b00, 1, 0);
    tbl[8]  = mk(0, 32'h0,    32'h0,        1, 32'h1000, 1, 0, 32'h0,        2'b00, 1, 0);
    tbl[9]  = mk(1, 32'h1003, 32'hDEADBEEF, 0, 32'h0,    1, 1, 32'h0,        2'b01, 1, 0);
    tbl[10] = mk(0, 32'h0,    32'h0,        0, 32'h0,    1, 1, 32'h0,        2'b10, 1, 1);
    tbl[11] = mk(0, 32'h0,    32'h0,        1, 32'h0,    1, 0, 32'h0,        2'b00, 1, 0);
    tbl[12] = mk(0, 32'h0,    32'h0,        1, 32'hC,    1, 0, 32'h0,        2'b00, 1, 0);
    tbl[13] = mk(0, 32'h0,    32'h0,        0, 32'h0,    1, 1, 32'hA00000AA, 2'b00, 1, 0);
    tbl[14] = mk(1, 32'h8,    32'h00000022, 0, 32'h0,    1, 1, 32'h00000033, 2'b00, 1, 0);
    tbl[15] = mk(1, 32'h8,    32'h00000055, 1, 32'h8,    1, 0, 32'h0,        2'b00, 1, 0);
    tbl[16] = mk(0, 32'h0,    32'h0,        1, 32'h8,    1, 0, 32'h0,        2'b00, 1, 0);
    tbl[17] = mk(0, 32'h0,    32'h0,        0, 32'h0,    1, 1, 32'h00000022, 2'b00, 1, 0);
    tbl[18] = mk(0, 32'h0,    32'h0,        0, 32'h0,    1, 1, 32'h00000055, 2'b00, 1, 0);
    tbl[19] = mk(0, 32'h0,    32'h0,        0, 32'h0,    1, 0, 32'h0,        2'b00, 1, 0);

    step_a(0, 0, 0, 0, 0, 1, 1);
    step_a(0, 0, 0, 0, 0, 1, 1);
    chk("reset rsp_valid", 64'(bus_a.rsp_valid), 64'(1'b0));
    chk("reset wr_err", 64'(bus_a.wr_err), 64'(1'b0));

    for (int i = 0; i < NV; i++) begin
      step_a(tbl[i].wr_en, tbl[i].wr_addr, tbl[i].wr_data,
             tbl[i].req_valid, tbl[i].req_addr, tbl[i].rsp_ready, 1'b0);
      chk_a($sformatf("row%0d", i), tbl[i].e_rv, tbl[i].e_data, tbl[i].e_err, tbl[i].e_rr);
      chk($sformatf("row%0d wr_err", i), 64'(bus_a.wr_err), 64'(tbl[i].e_we));
    end

    // Backpressure: 0x0, 0x4 accepted; stall 3 cycles once the first response shows.
    step_a(0, 0, 0, 1, 32'h0, 1, 0);
    chk_a("bp0", 0, 32'h0, 2'b00, 1);
    step_a(0, 0, 0, 1, 32'h4, 1, 0);
    chk_a("bp1", 0, 32'h0, 2'b00, 1);
    for (int i = 0; i < 3; i++) begin
      step_a(0, 0, 0, 1, 32'h8, 0, 0);
      chk_a($sformatf("bp_stall%0d", i), 1, 32'hA00000AA, 2'b00, 0);
    end
    step_a(0, 0, 0, 1, 32'h8, 1, 0);
    chk_a("bp_release", 1, 32'hA00000AA, 2'b00, 1);
    step_a(0, 0, 0, 0, 32'h0, 1, 0);
    chk_a("bp_second", 1, 32'h10000011, 2'b00, 1);
    step_a(0, 0, 0, 0, 32'h0, 1, 0);
    chk_a("bp_third", 1, 32'h00000055, 2'b00, 1);
    step_a(0, 0, 0, 0, 32'h0, 1, 0);
    chk_a("bp_drained", 0, 32'h0, 2'b00, 1);

    // Reset mid-flight, with a write presented during the reset cycle.
    step_a(0, 0, 0, 1, 32'h0, 1, 0);
    chk_a("rst_acc0", 0, 32'h0, 2'b00, 1);
    step_a(1, 32'hC, 32'h00000BAD, 1, 32'h4, 1, 1);
    chk_a("rst_acc1", 0, 32'h0, 2'b00, 1);
    for (int i = 0; i < 3; i++) begin
      step_a(0, 0, 0, 0, 32'h0, 1, 0);
      chk_a($sformatf("rst_quiet%0d", i), 0, 32'h0, 2'b00, 1);
      chk($sformatf("rst_quiet%0d wr_err", i), 64'(bus_a.wr_err), 64'(1'b0));
    end
    step_a(0, 0, 0, 1, 32'h0, 1, 0);
    step_a(0, 0, 0, 1, 32'h4, 1, 0);
    step_a(0, 0, 0, 1, 32'hC, 1, 0);
    chk_a("rst_rd0", 1, 32'hA00000AA, 2'b00, 1);
    step_a(0, 0, 0, 0, 32'h0, 1, 0);
    chk_a("rst_rd1", 1, 32'h10000011, 2'b00, 1);
    step_a(0, 0, 0, 0, 32'h0, 1, 0);
    chk_a("rst_rd2", 1, 32'h00000033, 2'b00, 1);

    // LATENCY=4 load/fetch on the second instance.
    rst_b = 1'b0;
    step_b(1, 32'h0, 32'hA00000AA, 0, 32'h0);
    chk_b("l4_init", 0, 32'h0);
    step_b(1, 32'h4, 32'h10000011, 0, 32'h0);
    step_b(0, 0, 0, 1, 32'h0);
    chk("l4_req_ready", 64'(bus_b.req_ready), 64'(1'b1));
    step_b(0, 0, 0, 1, 32'h4);
    chk_b("l4_n1", 0, 32'h0);
    step_b(0, 0, 0, 0, 32'h0);
    chk_b("l4_n2", 0, 32'h0);
    step_b(0, 0, 0, 0, 32'h0);
    chk_b("l4_n3", 0, 32'h0);
    step_b(0, 0, 0, 0, 32'h0);
    chk_b("l4_n4", 1, 32'hA00000AA);
    step_b(0, 0, 0, 0, 32'h0);
    chk_b("l4_n5", 1, 32'h10000011);
    step_b(0, 0, 0, 0, 32'h0);
    chk_b("l4_n6", 0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_pipelined.md
IMEM_PIPELINED -- requirements
Module: imem_pipelined

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the instruction word width in bits; legal values are 32 and 64.
REQ-002 Parameter ADDR_W, default 32, SHALL set the byte-address width.
REQ-003 Parameter DEPTH, default 1024, SHALL set the number of words in storage; it SHALL be a power of two.
REQ-004 Parameter LATENCY, default 1, SHALL set the request-to-response latency in cycles; legal range is 1..4.
REQ-005 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 req_valid  input  1  fetch request present.
REQ-008 req_ready  output  1  request accepted this cycle when high together with req_valid.
REQ-009 req_addr  input  ADDR_W  fetch byte address.
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_ready  input  1  consumer accepts the response.
REQ-012 rsp_data  output  DATA_W  fetched word.
REQ-013 rsp_err  output  2  response status: 00 ok, 01 misaligned, 10 out of range.
REQ-014 wr_en  input  1  load-port write strobe.
REQ-015 wr_addr  input  ADDR_W  load-port byte address.
REQ-016 wr_data  input  DATA_W  load-port write word.
REQ-017 wr_err  output  1  one-cycle pulse flagging a rejected write.

Function
REQ-018 Word index SHALL be addr >> log2(DATA_W/8).
- Misaligned: any low byte-offset bit nonzero.
- Out of range: word index >= DEPTH.
REQ-019 The read path SHALL be a LATENCY-stage pipeline in which each stage holds valid, data and err.
REQ-020 Advance condition adv SHALL be (!rsp_valid || rsp_ready); all stages SHALL shift only when adv is high, otherwise every stage SHALL hold its contents.
REQ-021 req_ready SHALL equal adv; it is combinational and SHALL NOT depend on req_valid.
REQ-022 A request accepted in cycle N SHALL appear on rsp_valid/rsp_data/rsp_err in cycle N+LATENCY when adv stays high throughout; each low-adv cycle SHALL delay it by one cycle.
REQ-023 Responses SHALL be returned strictly in request order, with no loss or duplication.
REQ-024 Sustained throughput SHALL be one response per cycle while req_valid and rsp_ready are both held high.
REQ-025 While rsp_valid is high and rsp_ready is low, rsp_data and rsp_err SHALL hold stable.
REQ-026 Misaligned takes priority over out of range. An erroring request SHALL:
- return rsp_data = 0 with the corresponding rsp_err;
- perform no storage read side effects.
REQ-027 Cycles in which a stage is empty SHALL carry valid = 0.
- rsp_data is don't-care while rsp_valid = 0.
- rsp_err SHALL be 00 while rsp_valid = 0.
REQ-028 Writes SHALL commit at the clock edge where wr_en = 1 and the address is aligned and in range; writes SHALL NOT depend on adv.
REQ-029 A write with a misaligned or out-of-range address SHALL be dropped, with wr_err = 1 in the following cycle only.
REQ-030 Read and write accepted in the same cycle to the same word SHALL be read-first: the read returns the old word and the new word is visible to requests accepted in later cycles.
REQ-031 Storage contents at configuration SHALL be all zeros.

Reset
REQ-032 While rst is high, all pipeline stage valids SHALL clear at the clock edge, giving rsp_valid = 0, rsp_err = 00, wr_err = 0.
REQ-033 Reset SHALL NOT alter storage contents.
REQ-034 Writes presented during a reset cycle SHALL be ignored.
REQ-035 req_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-036 Requests in flight when rst asserts mid-operation SHALL be discarded and never produce responses.

Verification
REQ-037 Bench SHALL cover, with LATENCY=2, DATA_W=32, DEPTH=1024:
- Load/fetch: write 0xA00000AA to 0x0 and 0x10000011 to 0x4, then fetch 0x0 and 0x4 back-to-back -> responses at N+2 and N+3: 0xA00000AA err 00, then 0x10000011 err 00.
- Backpressure: stream 0x0, 0x4, 0x8; hold rsp_ready low 3 cycles once rsp_valid rises -> req_ready low, rsp_data held stable, all three responses delivered in order, none lost.
- Errors: fetch 0x2 -> data 0, err 01; fetch 0x1000 -> data 0, err 10; write to 0x1003 -> wr_err pulses once and storage is unchanged.
- Read-first: write 0x55 to 0x8 in the same cycle as a fetch of 0x8 holding 0x22 -> response 0x22; next fetch of 0x8 -> 0x55.
- Reset mid-flight: accept two fetches, assert rst for 1 cycle -> no responses emerge, rsp_valid = 0, previously written words still read back intact.
- LATENCY=4 rerun of the load/fetch scenario -> first response exactly 4 cycles after acceptance.
